bin9_bcd_display: RTL and testbench
===================================

BIN9_BCD_DISPLAY -- requirements
Module: bin9_bcd_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles each digit stays lit (minimum 2).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 resultado  input  9  adder/subtractor result to display.
REQ-005 Sel  input  1  0 = resultado unsigned (0..511); 1 = resultado 9-bit two's complement.
REQ-006 in_valid  input  1  request to capture resultado and Sel this cycle.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  registered one-cycle pulse when new digits reach the display.
REQ-009 an  output  4  digit enables, active-low one-hot; an[0] = units, an[3] = sign.
REQ-010 seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.

Function
REQ-011 States: IDLE, SHIFT, DONE; busy SHALL be 1 whenever state != IDLE.
REQ-012 IDLE with in_valid=1 at edge N: latch sign and 9-bit magnitude, clear BCD accumulator, clear iteration counter, go to SHIFT.
REQ-013 sign SHALL be Sel & resultado[8]; magnitude SHALL be two's-complement negation of resultado when sign=1, else resultado unchanged (9-bit; -256 gives 256).
REQ-014 SHIFT: one double-dabble iteration per edge (add 3 to each BCD nibble >= 5, then shift left one bit with magnitude MSB entering); exactly 9 iterations at edges N+1..N+9, then DONE.
REQ-015 DONE at edge N+10: copy hundreds/tens/units and sign into display registers, done<=1, state<=IDLE; done SHALL be 1 only in cycle N+10..N+11.
REQ-016 in_valid while busy=1 SHALL be ignored (not queued); in_valid in the IDLE cycle after DONE starts a new conversion normally.
REQ-017 Display registers SHALL change only at the DONE edge; the previous value stays displayed during conversion.
REQ-018 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap the 2-bit digit index increments 0->1->2->3->0.
REQ-019 Digit 0/1/2 SHALL show units/tens/hundreds with standard 7-seg glyphs 0-9 (0 = 1000000, 1 = 1111001, 8 = 0000000); nibble > 9 SHALL show blank (1111111).
REQ-020 Digit 3 SHALL show minus (0111111) when displayed sign=1, else blank.
REQ-021 Scanning SHALL continue unaffected by conversions; an and seg SHALL be registered, changing together.

Reset
REQ-022 rst=1 SHALL, at the next edge, regardless of state (including mid-SHIFT): state<=IDLE, busy=0, done=0, display digits=0, sign=0, refresh counter=0, digit index=0.
REQ-023 First cycle after reset: an=1110, seg=1000000 (units shows 0); in-flight conversion discarded.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: hundreds digit blank when 0; tens digit blank when hundreds and tens both 0; units always shown; minus stays on digit 3.
REQ-025 Macro undefined: digits 0-2 always shown including leading zeros.

Verification
REQ-026 Reset, no input -> an cycles 1110,1101,1011,0111 every REFRESH_DIV (bench uses 4) cycles; seg 1000000,1000000,1000000,1111111 (macro off).
REQ-027 Sel=0, resultado=9'd510, in_valid at edge N -> busy high N+1..N+10, done pulse at N+10, digits 5,1,0, digit 3 blank.
REQ-028 Sel=1, resultado=9'h1F6 (-10) -> digits 0,1,0 with digit 3 = 0111111; macro on -> hundreds blank, digit 3 = 0111111.
REQ-029 Second in_valid at N+4 during conversion of 123 -> ignored, only 123 displayed, single done pulse.
REQ-030 rst asserted at N+5 mid-conversion of 255 -> busy=0 next cycle, display 000, no done pulse; subsequent in_valid with 7 -> displays 007 (macro off) / 7 (macro on).

Source files
------------

// File: rtl/bin9_bcd_display.sv
// bin9_bcd_display: converts a 9-bit adder/subtractor result (unsigned or
// two's complement) to BCD with a sequential double-dabble engine and drives
// a 4-digit multiplexed, active-low seven-segment display
// (an[0] = units, an[1] = tens, an[2] = hundreds, an[3] = sign).
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, leading
// zeros on the hundreds and tens digits are blanked; units is always shown.
module bin9_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] resultado,
    input  logic       Sel,
    input  logic       in_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [8:0]  mag;
    logic [11:0] bcd;
    logic [3:0]  iter;
    logic        sign_cap;

    logic [3:0]  disp_h;
    logic [3:0]  disp_t;
    logic [3:0]  disp_u;
    logic        disp_sign;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;

    logic        cap_sign;
    logic [8:0]  cap_mag;
    logic [10:0] bcd_adj;
    logic [3:0]  nib;
    logic        blank;
    logic        is_sign_digit;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Sign/magnitude split of the incoming operand; negating -256 wraps back to 256 in 9 bits
    always_comb begin
        cap_sign = Sel & resultado[8];
        cap_mag  = cap_sign ? (~resultado + 9'd1) : resultado;
    end

    // Add-3 correction for one double-dabble step; hundreds never exceeds 2 before a shift since the input is below 512, so it needs no correction
    always_comb begin
        bcd_adj = bcd[10:0];
        if (bcd[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd[3:0] + 4'd3;
        end
        if (bcd[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd[7:4] + 4'd3;
        end
    end

    // Conversion FSM: capture, nine shift iterations, then publish to the display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mag       <= 9'd0;
            bcd       <= 12'd0;
            iter      <= 4'd0;
            sign_cap  <= 1'b0;
            disp_h    <= 4'd0;
            disp_t    <= 4'd0;
            disp_u    <= 4'd0;
            disp_sign <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_cap <= cap_sign;
                        mag      <= cap_mag;
                        bcd      <= 12'd0;
                        iter     <= 4'd0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj, mag[8]};
                    mag  <= {mag[7:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd8) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_h    <= bcd[11:8];
                    disp_t    <= bcd[7:4];
                    disp_u    <= bcd[3:0];
                    disp_sign <= sign_cap;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running refresh timer that steps the scanned digit on every wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // Choose the nibble, anode pattern and blanking for the currently scanned digit
    always_comb begin
        nib           = 4'd0;
        blank         = 1'b0;
        is_sign_digit = 1'b0;
        an_next       = 4'b1111;
        case (digit_idx)
            2'd0: begin
                nib     = disp_u;
                an_next = 4'b1110;
            end
            2'd1: begin
                nib     = disp_t;
                an_next = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                blank   = (disp_h == 4'd0) && (disp_t == 4'd0);
`endif
            end
            2'd2: begin
                nib     = disp_h;
                an_next = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                blank   = (disp_h == 4'd0);
`endif
            end
            default: begin
                is_sign_digit = 1'b1;
                an_next       = 4'b0111;
            end
        endcase
        if (is_sign_digit) begin
            seg_next = disp_sign ? 7'b0111111 : 7'b1111111;
        end else if (blank) begin
            seg_next = 7'b1111111;
        end else begin
            seg_next = glyph(nib);
        end
    end

    // Register anodes and segments together so the pins never glitch between digits
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bin9_bcd_display.sv
// Testbench for bin9_bcd_display: scoreboard of expected display contents,
// pushed when a conversion is launched and popped once the display is scanned.
module tb_bin9_bcd_display;

    localparam int REFRESH_DIV = 4;

    logic       clk;
    logic       rst;
    logic [8:0] resultado;
    logic       sel;
    logic       in_valid;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;
    logic [27:0] expQueue[$];

    bin9_bcd_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk),
        .rst(rst),
        .resultado(resultado),
        .Sel(sel),
        .in_valid(in_valid),
        .busy(busy),
        .done(done),
        .an(an),
        .seg(seg)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] glyphOf(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {digit3, digit2, digit1, digit0} segment patterns
    function automatic logic [27:0] expectSegs(input logic [8:0] r, input logic s);
        logic sg;
        int m, h, t, u;
        logic [6:0] d0, d1, d2, d3;
        sg = s & r[8];
        m  = sg ? (512 - int'(r)) : int'(r);
        h  = m / 100;
        t  = (m / 10) % 10;
        u  = m % 10;
        d0 = glyphOf(u);
        d1 = glyphOf(t);
        d2 = glyphOf(h);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) d2 = 7'b1111111;
        if (h == 0 && t == 0) d1 = 7'b1111111;
`endif
        d3 = sg ? 7'b0111111 : 7'b1111111;
        return {d3, d2, d1, d0};
    endfunction

    // Launch a conversion at edge N, optionally inject a second in_valid or a reset, and watch busy/done
    task automatic applyStimulus(input logic [8:0] r, input logic s, input int extraAt, input int rstAt);
        int busyCount;
        int doneCount;
        int doneAt;
        @(negedge clk);
        resultado = r;
        sel       = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rstAt > 0) expQueue.push_back(expectSegs(9'd0, 1'b0));
        else           expQueue.push_back(expectSegs(r, s));
        busyCount = busy ? 1 : 0;
        doneCount = 0;
        doneAt    = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == extraAt) begin
                resultado = 9'd456;
                in_valid  = 1'b1;
            end
            rst = (k == rstAt);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rst      = 1'b0;
            if (k == rstAt) checkOutput("busy_after_rst", busy, 0);
            if (busy) busyCount++;
            if (done) begin
                doneCount++;
                doneAt = k;
            end
        end
        if (rstAt > 0) begin
            checkOutput("busy_cycles_rst", busyCount, rstAt);
            checkOutput("done_count_rst", doneCount, 0);
        end else begin
            checkOutput("busy_cycles", busyCount, 10);
            checkOutput("done_count", doneCount, 1);
            checkOutput("done_edge", doneAt, 10);
        end
    endtask

    // Scan the display until all four digits were seen and compare against the scoreboard head
    task automatic checkDisplay(input string tag);
        logic [27:0] got;
        logic [27:0] expv;
        logic [3:0]  seen;
        got  = '1;
        seen = 4'h0;
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin got[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin got[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
                default: checkOutput({tag, "_an_onehot"}, an, 4'b1110);
            endcase
        end
        checkOutput({tag, "_scan_seen"}, seen, 4'hF);
        if (expQueue.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 1, 0);
        end else begin
            expv = expQueue.pop_front();
            checkOutput({tag, "_d0"}, got[6:0],   expv[6:0]);
            checkOutput({tag, "_d1"}, got[13:7],  expv[13:7]);
            checkOutput({tag, "_d2"}, got[20:14], expv[20:14]);
            checkOutput({tag, "_d3"}, got[27:21], expv[27:21]);
        end
    endtask

    initial begin
        logic [3:0]  expAn[4];
        logic [27:0] zeroSegs;
        logic [6:0]  expSeg;
        expAn[0] = 4'b1110;
        expAn[1] = 4'b1101;
        expAn[2] = 4'b1011;
        expAn[3] = 4'b0111;
        rst       = 1'b1;
        in_valid  = 1'b0;
        resultado = 9'd0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_an", an, 4'b1110);
        checkOutput("reset_seg", seg, 7'b1000000);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);

        // Idle scan after reset: each anode held for REFRESH_DIV cycles
        @(negedge clk);
        rst = 1'b0;
        zeroSegs = expectSegs(9'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            expSeg = zeroSegs[7*(i/4) +: 7];
            checkOutput("scan_an", an, expAn[i/4]);
            checkOutput("scan_seg", seg, expSeg);
        end

        applyStimulus(9'd510, 1'b0, 0, 0);
        checkDisplay("u510");
        applyStimulus(9'h1F6, 1'b1, 0, 0);
        checkDisplay("s_m10");
        applyStimulus(9'd123, 1'b0, 4, 0);
        checkDisplay("u123_ignore");
        applyStimulus(9'd255, 1'b0, 0, 5);
        checkDisplay("rst_mid");
        applyStimulus(9'd7, 1'b0, 0, 0);
        checkDisplay("u7");
        applyStimulus(9'h100, 1'b1, 0, 0);
        checkDisplay("s_m256");
        applyStimulus(9'h1FF, 1'b0, 0, 0);
        checkDisplay("u511");
        applyStimulus(9'h1FF, 1'b1, 0, 0);
        checkDisplay("s_m1");
        applyStimulus(9'd0, 1'b1, 0, 0);
        checkDisplay("s_0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
